// File: rtl/conv2_mac5x5.sv
// 5x5 signed MAC stage: window x runtime-loaded kernel + bias, rounded, saturated, optional ReLU.
// Latency 4 cycles from the accepting edge; no backpressure, drops (and flags) windows when not in RUN.
module conv2_mac5x5 #(
  parameter int DATA_BITS   = 12,
  parameter int WEIGHT_BITS = 8,
  parameter int FRAC_BITS   = 7,
  parameter int OUT_PIXELS  = 64,
  parameter int RELU_EN     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [25*DATA_BITS-1:0]   win_in,
  input  logic                      w_load_start,
  input  logic                      w_load_valid,
  input  logic [WEIGHT_BITS-1:0]    w_load_data,
  output logic                      weights_ready,
  output logic [DATA_BITS-1:0]      data_out,
  output logic                      valid_out,
  output logic                      frame_done,
  output logic                      err_drop
);

  localparam int N_TAPS    = 25;
  localparam int ACC_BITS  = DATA_BITS + WEIGHT_BITS + 5;
  localparam int PROD_BITS = DATA_BITS + WEIGHT_BITS;
  localparam int R_BITS    = ACC_BITS - FRAC_BITS + 1;
  localparam int CNT_BITS  = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;
  localparam int IDX_BITS  = 5;

  localparam logic signed [R_BITS-1:0] SAT_MAX = R_BITS'((1 <<< (DATA_BITS-1)) - 1);
  localparam logic signed [R_BITS-1:0] SAT_MIN = R_BITS'(-(1 <<< (DATA_BITS-1)));

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                          state_q, state_d;
  logic [IDX_BITS-1:0]             idx_q, idx_d;
  logic signed [WEIGHT_BITS-1:0]   w_q [N_TAPS];
  logic signed [WEIGHT_BITS-1:0]   w_d [N_TAPS];
  logic signed [WEIGHT_BITS-1:0]   bias_q, bias_d;
  logic                            ready_q, ready_d;
  logic                            err_q, err_d;

  logic                            v0_q, v0_d;
  logic signed [DATA_BITS-1:0]     win_q [N_TAPS];
  logic signed [DATA_BITS-1:0]     win_d [N_TAPS];
  logic                            v1_q, v1_d;
  logic signed [PROD_BITS-1:0]     prod_q [N_TAPS];
  logic signed [PROD_BITS-1:0]     prod_d [N_TAPS];
  logic signed [WEIGHT_BITS-1:0]   bias1_q, bias1_d;
  logic                            v2_q, v2_d;
  logic signed [ACC_BITS-1:0]      row_q [5];
  logic signed [ACC_BITS-1:0]      row_d [5];
  logic signed [WEIGHT_BITS-1:0]   bias2_q, bias2_d;
  logic                            v3_q, v3_d;
  logic signed [ACC_BITS-1:0]      total_q, total_d;
  logic                            vout_q, vout_d;
  logic signed [DATA_BITS-1:0]     dout_q, dout_d;
  logic                            fd_q, fd_d;
  logic [CNT_BITS-1:0]             cnt_q, cnt_d;

  logic                            accept;
  logic signed [ACC_BITS:0]        rnd;
  logic signed [R_BITS-1:0]        rq;
  logic signed [DATA_BITS-1:0]     res;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_d     = w_q;
    bias_d  = bias_q;

    // A start pulse always wins: it restarts the load and masks w_load_valid and valid_in.
    if (w_load_start) begin
      state_d = LOAD;
      idx_d   = '0;
    end else if (state_q == LOAD && w_load_valid) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (idx_q == IDX_BITS'(k)) w_d[k] = w_load_data;
      end
      if (idx_q == IDX_BITS'(N_TAPS)) begin
        bias_d  = w_load_data;
        state_d = RUN;
      end
      idx_d = idx_q + IDX_BITS'(1);
    end

    ready_d = (state_d == RUN);
    accept  = valid_in && (state_q == RUN) && !w_load_start;
    err_d   = err_q | (valid_in & ~accept);

    v0_d  = accept;
    win_d = win_q;
    if (accept) begin
      for (int k = 0; k < N_TAPS; k++) win_d[k] = win_in[k*DATA_BITS +: DATA_BITS];
    end

    // Kernel and bias are sampled here so a reload cannot disturb windows already in flight.
    v1_d    = v0_q;
    prod_d  = prod_q;
    bias1_d = bias1_q;
    if (v0_q) begin
      for (int k = 0; k < N_TAPS; k++) prod_d[k] = PROD_BITS'(win_q[k]) * PROD_BITS'(w_q[k]);
      bias1_d = bias_q;
    end

    v2_d    = v1_q;
    row_d   = row_q;
    bias2_d = bias2_q;
    if (v1_q) begin
      for (int r = 0; r < 5; r++) begin
        row_d[r] = '0;
        for (int c = 0; c < 5; c++) row_d[r] = row_d[r] + ACC_BITS'(prod_q[r*5+c]);
      end
      bias2_d = bias1_q;
    end

    v3_d    = v2_q;
    total_d = total_q;
    if (v2_q) begin
      total_d = ACC_BITS'(bias2_q) <<< FRAC_BITS;
      for (int r = 0; r < 5; r++) total_d = total_d + row_q[r];
    end

    rnd = (ACC_BITS+1)'(total_q) + (ACC_BITS+1)'(1 <<< (FRAC_BITS-1));
    rq  = R_BITS'(rnd >>> FRAC_BITS);
    if (rq > SAT_MAX)      res = SAT_MAX[DATA_BITS-1:0];
    else if (rq < SAT_MIN) res = SAT_MIN[DATA_BITS-1:0];
    else                   res = rq[DATA_BITS-1:0];
    if (RELU_EN != 0 && rq[R_BITS-1]) res = '0;

    vout_d = v3_q;
    dout_d = dout_q;
    fd_d   = 1'b0;
    cnt_d  = cnt_q;
    if (v3_q) begin
      dout_d = res;
      if (cnt_q == CNT_BITS'(OUT_PIXELS-1)) begin
        fd_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bias_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      bias1_q <= '0;
      v2_q    <= 1'b0;
      bias2_q <= '0;
      v3_q    <= 1'b0;
      total_q <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < N_TAPS; k++) begin
        w_q[k]    <= '0;
        win_q[k]  <= '0;
        prod_q[k] <= '0;
      end
      for (int r = 0; r < 5; r++) row_q[r] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      v0_q    <= v0_d;
      win_q   <= win_d;
      v1_q    <= v1_d;
      prod_q  <= prod_d;
      bias1_q <= bias1_d;
      v2_q    <= v2_d;
      row_q   <= row_d;
      bias2_q <= bias2_d;
      v3_q    <= v3_d;
      total_q <= total_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign weights_ready = ready_q;
  assign data_out      = dout_q;
  assign valid_out     = vout_q;
  assign frame_done    = fd_q;
  assign err_drop      = err_q;

endmodule

// File: tb/tb_conv2_mac5x5.sv
// Bench for conv2_mac5x5: random windows/kernels scored against an arithmetic reference model,
// two instances (ReLU on/off) share stimulus.
module tb_conv2_mac5x5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic [299:0]       win_in = '0;
  logic               w_load_start = 1'b0;
  logic               w_load_valid = 1'b0;
  logic [7:0]         w_load_data = '0;

  logic               ready_a, ready_b;
  logic signed [11:0] dout_a, dout_b;
  logic               vout_a, vout_b;
  logic               fd_a, fd_b;
  logic               err_a, err_b;

  conv2_mac5x5 #(.RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .win_in(win_in),
    .w_load_start(w_load_start), .w_load_valid(w_load_valid), .w_load_data(w_load_data),
    .weights_ready(ready_a), .data_out(dout_a), .valid_out(vout_a),
    .frame_done(fd_a), .err_drop(err_a)
  );

  conv2_mac5x5 #(.RELU_EN(0)) dut_lin (
    .clk(clk), .rst(rst), .valid_in(valid_in), .win_in(win_in),
    .w_load_start(w_load_start), .w_load_valid(w_load_valid), .w_load_data(w_load_data),
    .weights_ready(ready_b), .data_out(dout_b), .valid_out(vout_b),
    .frame_done(fd_b), .err_drop(err_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v_relu;
    int v_lin;
    bit fd;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   win_t[25];
  int   cur_w[25];
  int   cur_b;
  int   nw[25];
  int   nb;
  bit   tb_ready = 0;
  int   out_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: plain integer convolution, round half up, clamp, optional ReLU.
  function automatic int model_val(input bit relu);
    longint acc;
    acc = 0;
    for (int k = 0; k < 25; k++) acc += longint'(win_t[k]) * longint'(cur_w[k]);
    acc += longint'(cur_b) * 128;
    acc = (acc + 64) >>> 7;
    if (acc > 2047) acc = 2047;
    if (acc < -2048) acc = -2048;
    if (relu && acc < 0) acc = 0;
    return int'(acc);
  endfunction

  task automatic rand_win(input int span);
    for (int k = 0; k < 25; k++) win_t[k] = $urandom_range(0, 2*span - 1) - span;
  endtask

  task automatic send_win();
    exp_t e;
    for (int k = 0; k < 25; k++) win_in[k*12 +: 12] = win_t[k][11:0];
    valid_in = 1'b1;
    if (tb_ready && !w_load_start) begin
      e.v_relu = model_val(1);
      e.v_lin  = model_val(0);
      out_cnt++;
      e.fd = (out_cnt == 64);
      if (out_cnt == 64) out_cnt = 0;
      e.cyc = cyc + 5;
      sb.push_back(e);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic load_kernel(input bit junk);
    int i;
    w_load_start = 1'b1;
    w_load_valid = 1'b1;
    w_load_data  = 8'($urandom);
    tb_ready = 0;
    if (junk) begin
      valid_in = 1'b1;
      win_in = {10{$urandom}};
    end
    @(negedge clk);
    w_load_start = 1'b0;
    i = 0;
    while (i < 26) begin
      if (junk) begin
        valid_in = 1'($urandom);
        win_in = {10{$urandom}};
      end else begin
        valid_in = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) begin
        w_load_valid = 1'b0;
        w_load_data  = 8'($urandom);
      end else begin
        w_load_valid = 1'b1;
        w_load_data  = (i < 25) ? nw[i][7:0] : nb[7:0];
        if (i == 25) chk("ready_low_before_bias", int'(ready_a), 0);
        i++;
      end
      @(negedge clk);
    end
    w_load_valid = 1'b0;
    valid_in = 1'b0;
    for (int k = 0; k < 25; k++) cur_w[k] = nw[k];
    cur_b = nb;
    tb_ready = 1;
    chk("ready_after_load", int'(ready_a), 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    valid_in = 1'b0;
    w_load_start = 1'b0;
    w_load_valid = 1'b0;
    sb.delete();
    out_cnt = 0;
    tb_ready = 0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_kernel(input int tap12, input int others, input int b);
    for (int k = 0; k < 25; k++) nw[k] = others;
    nw[12] = tap12;
    nb = b;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (vout_a != vout_b || (fd_a && !vout_a)) begin
        checks++;
        failures++;
        $display("FAIL valid_consistency valid_a=%0b valid_b=%0b fd=%0b", vout_a, vout_b, fd_a);
      end
      if (vout_a) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output data=%0d expected no output", dout_a);
        end else begin
          e = sb.pop_front();
          chk("data_relu", int'(dout_a), e.v_relu);
          chk("data_lin", int'(dout_b), e.v_lin);
          chk("frame_done", int'(fd_a), int'(e.fd));
          chk("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < 25; k++) begin cur_w[k] = 0; win_t[k] = 0; end
    cur_b = 0;
    do_reset(3);
    chk("rst_valid_out", int'(vout_a), 0);
    chk("rst_data_out", int'(dout_a), 0);
    chk("rst_frame_done", int'(fd_a), 0);
    chk("rst_weights_ready", int'(ready_a), 0);
    chk("rst_err_drop", int'(err_a), 0);

    // Window before any kernel load is dropped
    rand_win(2048);
    send_win();
    chk("err_drop_idle", int'(err_a), 1);
    idle(8);
    do_reset(2);
    chk("err_clear_by_rst", int'(err_a), 0);

    // Centre tap 64 (0.5) on 100 -> 50
    set_kernel(64, 0, 0);
    load_kernel(0);
    rand_win(2048); win_t[12] = 100;
    send_win();
    idle(6);

    // Rounding half up at unit weight
    set_kernel(1, 0, 0);
    load_kernel(0);
    rand_win(2048); win_t[12] = 64;
    send_win();
    win_t[12] = 63;
    send_win();
    win_t[12] = -64;
    send_win();
    win_t[12] = -65;
    send_win();

    // Positive and negative saturation
    set_kernel(127, 127, 0);
    load_kernel(0);
    for (int k = 0; k < 25; k++) win_t[k] = 2047;
    send_win();
    for (int k = 0; k < 25; k++) win_t[k] = -2048;
    send_win();

    // Negative result: ReLU vs linear; bias only
    set_kernel(-128, 0, 0);
    load_kernel(0);
    rand_win(2048); win_t[12] = 100;
    send_win();
    set_kernel(0, 0, 3);
    load_kernel(0);
    rand_win(2048);
    send_win();
    idle(6);
    chk("err_still_clear", int'(err_a), 0);

    // Reload right behind in-flight windows, with windows arriving during the reload
    for (int k = 0; k < 25; k++) nw[k] = $urandom_range(0, 255) - 128;
    nb = $urandom_range(0, 255) - 128;
    load_kernel(0);
    rand_win(256); send_win();
    rand_win(256); send_win();
    for (int k = 0; k < 25; k++) nw[k] = $urandom_range(0, 255) - 128;
    nb = $urandom_range(0, 255) - 128;
    load_kernel(1);
    chk("err_drop_reload", int'(err_a), 1);
    idle(6);

    // Randomized traffic with bubbles and occasional reloads
    for (int it = 0; it < 300; it++) begin
      n = $urandom_range(0, 99);
      if (n < 3) begin
        for (int k = 0; k < 25; k++) nw[k] = $urandom_range(0, 255) - 128;
        nb = $urandom_range(0, 255) - 128;
        load_kernel(0);
      end else if (n < 75) begin
        rand_win(($urandom_range(0, 1) == 1) ? 2048 : 128);
        send_win();
      end else begin
        idle(1);
      end
    end
    idle(8);

    // Frame counting: 65 back-to-back windows after a fresh reset
    do_reset(2);
    for (int k = 0; k < 25; k++) nw[k] = $urandom_range(0, 63) - 32;
    nb = $urandom_range(0, 63) - 32;
    load_kernel(0);
    for (int j = 0; j < 65; j++) begin
      rand_win(2048);
      send_win();
    end
    idle(8);

    // Reset with three windows in flight
    rand_win(2048); send_win();
    rand_win(2048); send_win();
    rand_win(2048); send_win();
    do_reset(1);
    chk("rst_flight_ready", int'(ready_a), 0);
    chk("rst_flight_data", int'(dout_a), 0);
    chk("rst_flight_valid", int'(vout_a), 0);
    idle(10);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
